// File: rtl/ps2_keycode_encoder.sv
// ============================================================================
// Module   : ps2_keycode_encoder
// Purpose  : PS/2 scan-code set 2 receiver that maintains a two-slot HID-style
//            keycode word (W/A/S/D/Space) for the player-motion logic.
// Options  : define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keycode_encoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        keycode_valid,
    output logic        frame_err
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Set-2 scan code to HID usage; 8'h00 marks an unsupported key.
    function automatic logic [7:0] hid_of(input logic [7:0] sc);
        case (sc)
            8'h1D:   hid_of = 8'h1A;
            8'h1C:   hid_of = 8'h04;
            8'h1B:   hid_of = 8'h16;
            8'h23:   hid_of = 8'h07;
            8'h29:   hid_of = 8'h2C;
            default: hid_of = 8'h00;
        endcase
    endfunction

    logic        pclk_s1_q, pclk_s2_q, pclk_prev_q;
    logic        pdat_s1_q, pdat_s2_q;
    logic        edge_q, bit_q;

    state_t      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic        byte_ok;
    logic        ferr_d, ferr_q;
    logic        parity_ok;

    logic        brk_q, brk_d, ext_q, ext_d;
    logic [15:0] keycode_q, keycode_d;
    logic        kvalid_q;
    logic [7:0]  hid;

    // Synchronize the pins (idle-high) and register the falling-edge pulse with its data bit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pclk_s1_q   <= 1'b1;
            pclk_s2_q   <= 1'b1;
            pclk_prev_q <= 1'b1;
            pdat_s1_q   <= 1'b1;
            pdat_s2_q   <= 1'b1;
            edge_q      <= 1'b0;
            bit_q       <= 1'b1;
        end else begin
            pclk_s1_q   <= ps2_clk;
            pclk_s2_q   <= pclk_s1_q;
            pclk_prev_q <= pclk_s2_q;
            pdat_s1_q   <= ps2_data;
            pdat_s2_q   <= pdat_s1_q;
            edge_q      <= pclk_prev_q & ~pclk_s2_q;
            bit_q       <= pdat_s2_q;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    // Receive FSM state and frame datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            to_q     <= to_d;
        end
    end

    // Frame sequencing, stop/parity validation and inter-edge timeout.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        to_d     = '0;
        byte_ok  = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A high start bit is treated as line noise.
                if (edge_q && !bit_q) begin
                    state_d  = S_DATA;
                    bitcnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (edge_q) begin
                    shift_d  = {bit_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (edge_q) begin
                    par_d   = bit_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (edge_q) begin
                    state_d = S_IDLE;
                    if (bit_q && parity_ok) byte_ok = 1'b1;
                    else                    ferr_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Any edge keeps the counter at zero via the default above.
        if (state_q != S_IDLE && !edge_q) begin
            if (to_q == TO_LAST) begin
                ferr_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    // Decoder prefix flags and the registered keycode / pulse outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            keycode_q <= 16'h0000;
            kvalid_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            keycode_q <= keycode_d;
            kvalid_q  <= (keycode_d != keycode_q);
            ferr_q    <= ferr_d;
        end
    end

    // Byte decoder: prefix tracking and two-slot make/break bookkeeping.
    always_comb begin
        brk_d     = brk_q;
        ext_d     = ext_q;
        keycode_d = keycode_q;
        hid       = hid_of(shift_q);
        if (byte_ok) begin
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                // Extended keys share set-2 codes with ours, so they are ignored.
                if (!ext_q && hid != 8'h00) begin
                    if (!brk_q) begin
                        if (keycode_q[15:8] != hid && keycode_q[7:0] != hid) begin
                            if (keycode_q[15:8] == 8'h00)
                                keycode_d = {hid, keycode_q[7:0]};
                            else if (keycode_q[7:0] == 8'h00)
                                keycode_d = {keycode_q[15:8], hid};
                        end
                    end else begin
                        if (keycode_q[7:0] == hid)
                            keycode_d = {keycode_q[15:8], 8'h00};
                        else if (keycode_q[15:8] == hid)
                            keycode_d = {keycode_q[7:0], 8'h00};
                    end
                end
            end
        end
    end

    assign keycode       = keycode_q;
    assign keycode_valid = kvalid_q;
    assign frame_err     = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keycode_encoder.sv
// ============================================================================
// Module   : tb_ps2_keycode_encoder
// Purpose  : Scoreboard bench for ps2_keycode_encoder: directed PS/2 frames,
//            expected keycode/frame_err events queued and checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_keycode_encoder;

    localparam int TO   = 100;   // short timeout keeps the stall test brief
    localparam int HALF = 8;     // Clk cycles per PS/2 clock half-period

    typedef struct packed {
        logic        is_err;
        logic [15:0] val;
    } ev_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        keycode_valid;
    logic        frame_err;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    ps2_keycode_encoder #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .keycode       (keycode),
        .keycode_valid (keycode_valid),
        .frame_err     (frame_err)
    );

    always #5 Clk = ~Clk;

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (!Reset && (keycode_valid || frame_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b keycode=%h, required no pulse",
                         keycode_valid, frame_err, keycode);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.is_err) begin
                    if (!frame_err || keycode_valid) begin
                        errors++;
                        $display("FAIL frame_err_event: valid=%0b err=%0b, required err=1 valid=0",
                                 keycode_valid, frame_err);
                    end
                end else if (!keycode_valid || frame_err || keycode !== e.val) begin
                    errors++;
                    $display("FAIL keycode_event: valid=%0b err=%0b keycode=%h, required valid=1 keycode=%h",
                             keycode_valid, frame_err, keycode, e.val);
                end
            end
        end
    end

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_key(input logic [15:0] v);
        exp_q.push_back('{is_err: 1'b0, val: v});
    endtask

    task automatic expect_err();
        exp_q.push_back('{is_err: 1'b1, val: 16'h0000});
    endtask

    // Drive n bits of an LSB-first frame, then leave the line idle.
    task automatic ps2_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(posedge Clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge Clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge Clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic bad_par);
        logic p;
        p = (~^b) ^ bad_par;
        ps2_bits({stop, p, b, 1'b0}, 11);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send(b, 1'b1, 1'b0);
    endtask

    // Wait (bounded) for the monitor to consume every expectation.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge Clk);
            n++;
        end
        repeat (4) @(posedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d events outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk16("reset_keycode", keycode, 16'h0000);
        repeat (2) @(negedge Clk);
        chk16("reset_pulses", {14'd0, keycode_valid, frame_err}, 16'h0000);
        exp_q.delete();
        Reset = 1'b0;
        repeat (4) @(posedge Clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge Clk);
        do_reset();

        // Single make.
        expect_key(16'h0400);
        send_ok(8'h1C);
        drain("single_make");
        do_reset();

        // Two makes, typematic repeat, then break with compaction.
        expect_key(16'h0400);
        expect_key(16'h041A);
        expect_key(16'h1A00);
        send_ok(8'h1C); send_ok(8'h1D); send_ok(8'h1C);
        send_ok(8'hF0); send_ok(8'h1C);
        drain("compaction");
        do_reset();

        // Third key dropped, break of an unheld key ignored.
        expect_key(16'h0400);
        expect_key(16'h041A);
        send_ok(8'h1C); send_ok(8'h1D); send_ok(8'h23);
        send_ok(8'hF0); send_ok(8'h23);
        drain("full_slots");
        chk16("full_slots_keycode", keycode, 16'h041A);
        do_reset();

        // Extended prefix discard and break of unheld key; flags clear afterwards.
        send_ok(8'hE0); send_ok(8'h1C);
        send_ok(8'hF0); send_ok(8'h29);
        drain("prefix");
        chk16("prefix_keycode", keycode, 16'h0000);
        expect_key(16'h1600);
        send_ok(8'h1B);
        drain("after_prefix");
        do_reset();

        // Bad stop bit, then a stalled frame, then a good frame.
        expect_err();
        send(8'h1C, 1'b0, 1'b0);
        drain("bad_stop");
        chk16("bad_stop_keycode", keycode, 16'h0000);
        expect_err();
        ps2_bits({1'b1, 1'b1, 8'h1C, 1'b0}, 4);
        repeat (TO + 20) @(posedge Clk);
        drain("timeout");
        chk16("timeout_keycode", keycode, 16'h0000);
        expect_key(16'h0400);
        send_ok(8'h1C);
        drain("recover");
        do_reset();

        // Even (wrong) parity on 1B.
`ifdef PS2_PARITY_CHECK_EN
        expect_err();
        send(8'h1B, 1'b1, 1'b1);
        drain("parity_reject");
        chk16("parity_keycode", keycode, 16'h0000);
`else
        expect_key(16'h1600);
        send(8'h1B, 1'b1, 1'b1);
        drain("parity_ignored");
`endif
        do_reset();

        // Reset in the middle of a frame.
        expect_key(16'h0400);
        send_ok(8'h1C);
        drain("pre_midreset");
        ps2_bits({1'b1, 1'b1, 8'h1D, 1'b0}, 4);
        do_reset();
        expect_key(16'h1A00);
        send_ok(8'h1D);
        drain("post_midreset");
        chk16("final_keycode", keycode, 16'h1A00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_keycode_encoder.md
# ps2_keycode_encoder

Receives PS/2 scan-code set 2 frames from the keyboard pins and produces the 16-bit two-slot HID-style `keycode` word consumed by the player-motion logic. Key codes: W=8'h1A, A=8'h04, S=8'h16, D=8'h07, Space=8'h2C. A single held key always sits in `keycode[15:8]` (e.g. A held -> 16'h0400). The block sits between the board PS/2 pins and the motion/sprite modules, replacing the software keycode path.

## Interface
- `TIMEOUT_CYCLES`, 50000, `Clk` cycles without a PS/2 falling edge before an in-progress frame is abandoned.
- `Clk` input 1: system clock, single clock domain.
- `Reset` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `keycode` output 16: `[15:8]` first held key, `[7:0]` second held key; 8'h00 = empty slot.
- `keycode_valid` output 1: one-cycle pulse whenever `keycode` changes value.
- `frame_err` output 1: one-cycle pulse on a discarded frame (bad stop, parity, or timeout).

## Operation
- `ps2_clk` and `ps2_data` each pass through a 2-flop synchronizer. A falling edge is sampled pclk 1 followed by 0 on the synchronized clock. Data is sampled on that edge.
- **Receive FSM:**
  - IDLE: on an edge with data 0, go to DATA with bit count 0. An edge with data 1 is ignored as a glitch.
  - DATA: shift 8 bits LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: data 1 means the byte is accepted. Data 0 pulses `frame_err` and discards the byte. Either way, return to IDLE.
  - Timeout: in any state other than IDLE, `TIMEOUT_CYCLES` consecutive cycles with no edge pulse `frame_err` and return the FSM to IDLE. The counter clears on every edge.
- **Byte decoder:**
  - 8'hF0 sets `brk`. 8'hE0 sets `ext`. Neither changes `keycode`.
  - Any other byte is a code. Set-2 to HID translation: 1D->1A, 1C->04, 1B->16, 23->07, 29->2C. All other codes are unsupported.
  - Any code clears both `brk` and `ext`. A code received with `ext` set is discarded, whatever its value.
- **Slot update on a supported code H:**
  - Make, H already in either slot (typematic repeat): no change.
  - Make, H not held: `[15:8]` empty -> place in `[15:8]`; else `[7:0]` empty -> place in `[7:0]`; else drop.
  - Break, H in `[7:0]`: clear `[7:0]`.
  - Break, H in `[15:8]`: `[15:8]` <- `[7:0]`, then `[7:0]` <- 0 (compaction).
  - Break, H not held: no change.
- Unsupported make or break codes leave `keycode` unchanged.
- **Reset values:** `keycode`=16'h0000, `keycode_valid`=0, `frame_err`=0, FSM=IDLE, `brk`=`ext`=0, timeout counter 0. Reset mid-frame discards the partial byte and flags.

## Timing
- Falling edge on the `ps2_clk` pin to internal edge pulse: 3 `Clk` cycles (2 synchronizer + 1 edge register).
- Accepted stop bit to updated `keycode`: registered on the cycle after the edge pulse, with `keycode_valid` high in that same cycle.
- A byte decode that produces no change raises no `keycode_valid`.
- `frame_err` is a single cycle, aligned to the cycle after the offending edge pulse or timeout expiry.
- Minimum `Clk` is 8x the PS/2 clock (10–16.7 kHz); `TIMEOUT_CYCLES` must exceed one PS/2 bit period in `Clk` cycles.

## Configuration
- `PS2_PARITY_CHECK_EN` defined:
  - In STOP, the byte is accepted only if the 8 data bits plus the parity bit have odd parity.
  - Otherwise `frame_err` pulses and the byte is discarded.
- Undefined: the parity bit is captured but ignored, and the byte is accepted on a valid stop bit alone.

## Test plan
- After `Reset`, frame 8'h1C (A make) -> `keycode`=16'h0400, one `keycode_valid` pulse; `frame_err` stays 0.
- Frames 1C, 1D, 1C (A make, W make, A repeat) -> `keycode` 16'h0400 then 16'h041A; the repeat produces no pulse. Then F0 1C -> 16'h1A00 (compaction).
- A, W, D makes -> 16'h041A; the D make is dropped. F0 23 -> no change.
- E0 1C, then F0 29 with nothing held -> `keycode` stays 16'h0000, no pulses. `brk`/`ext` are cleared, so a following 1B gives 16'h1600.
- Frame 8'h1C with the stop bit 0, and a frame stalled after 4 bits for `TIMEOUT_CYCLES` -> one `frame_err` pulse each, `keycode` unchanged. The next good frame is decoded correctly.
- With `PS2_PARITY_CHECK_EN`: 8'h1B sent with even parity -> `frame_err` pulse, `keycode` unchanged. Same frame without the macro -> `keycode`=16'h1600.
- `Reset` asserted mid-frame -> `keycode`=16'h0000 immediately. A complete frame after release decodes normally.
